lock_key_loader: RTL and testbench

//  Serial key-load controller for the locked c432 netlist. Accepts a key stream over a

---
 rtl/lock_key_loader.sv | 146 ++++++++++++++
 tb/tb_lock_key_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lock_key_loader.sv
// Serial key-load controller for the locked c432 core: shifts in key + checksum,
// verifies the XOR fold and only then exposes the key; repeated failures lock out.
module lock_key_loader #(
  parameter int unsigned     KEY_W    = 18,
  parameter int unsigned     MUX_W    = 4,
  parameter int unsigned     CHK_W    = 4,
  parameter int unsigned     MAX_FAIL = 3,
  parameter logic [KEY_W-1:0] DECOY   = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            clear,
  input  logic                            sin_data,
  input  logic                            sin_valid,
  output logic                            sin_ready,
  output logic [MUX_W-1:0]                key_p,
  output logic [KEY_W-MUX_W-1:0]          key_x,
  output logic                            key_valid,
  output logic                            busy,
  output logic                            err,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int unsigned TOT_W  = KEY_W + CHK_W;
  localparam int unsigned CNT_W  = $clog2(TOT_W);
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StActive, StLockout} state_e;

  state_e              state_q, state_d;
  logic [TOT_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                lock_q, lock_d;
  logic [KEY_W-1:0]    kout_q, kout_d;
  logic [KEY_W-1:0]    key_w;
  logic [CHK_W-1:0]    chk_w, fold;
  logic                xfer;

  assign key_w    = sr_q[TOT_W-1:CHK_W];
  assign chk_w    = sr_q[CHK_W-1:0];
  assign xfer     = sin_valid & ready_q;
  assign fail_inc = fail_q + 1'b1;

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      fold[i % CHK_W] = fold[i % CHK_W] ^ key_w[i];
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    err_d   = 1'b0;
    if (clear && state_q != StLockout) begin
      state_d = StIdle;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StLoad;
            sr_d    = '0;
            cnt_d   = '0;
          end
        end
        StLoad: begin
          if (xfer) begin
            sr_d  = {sr_q[TOT_W-2:0], sin_data};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TOT_W - 1)) state_d = StCheck;
          end
        end
        StCheck: begin
          if (fold == chk_w) begin
            state_d = StActive;
            fail_d  = '0;
          end else begin
            err_d   = 1'b1;
            sr_d    = '0;
            fail_d  = fail_inc;
            state_d = (fail_inc == FAIL_W'(MAX_FAIL)) ? StLockout : StIdle;
          end
        end
        StActive:  ;
        StLockout: ;
        default:   state_d = StIdle;
      endcase
    end
  end

  // key_valid lags ACTIVE entry by one cycle so the key register is settled before exposure
  always_comb begin
    valid_d = (state_q == StActive) && (state_d == StActive);
    kout_d  = valid_d ? key_w : DECOY;
    ready_d = (state_d == StLoad);
    busy_d  = (state_d == StLoad) || (state_d == StCheck);
    lock_d  = (state_d == StLockout);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
      kout_q  <= DECOY;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
      kout_q  <= kout_d;
    end
  end

  assign sin_ready = ready_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign lockout   = lock_q;
  assign fail_cnt  = fail_q;
  assign key_p     = kout_q[MUX_W-1:0];
  assign key_x     = kout_q[KEY_W-1:MUX_W];

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: good/bad loads, stalls, abort, clear, lockout, async reset.
module tb_lock_key_loader;
  logic        clk = 1'b0;
  logic        rst_n, start, clear, sin_data, sin_valid;
  logic        sin_ready, key_valid, busy, err, lockout;
  logic [3:0]  key_p;
  logic [13:0] key_x;
  logic [1:0]  fail_cnt;

  int tests = 0;
  int fails = 0;

  lock_key_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .sin_data(sin_data), .sin_valid(sin_valid), .sin_ready(sin_ready),
    .key_p(key_p), .key_x(key_x), .key_valid(key_valid), .busy(busy),
    .err(err), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] GoodKey = 18'h2A5C3;
  localparam logic [3:0]  GoodChk = 4'h2;
  localparam logic [3:0]  BadChk  = 4'h3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Streams the first nbits of {k,c} MSB-first; optional idle cycle before each bit.
  task automatic stream(input logic [17:0] k, input logic [3:0] c, input bit gaps,
                        input int nbits);
    logic [21:0] v;
    v = {k, c};
    for (int i = 0; i < nbits; i++) begin
      if (gaps) begin
        sin_valid = 1'b0;
        step();
      end
      for (int w = 0; w < 20 && !sin_ready; w++) step();
      if (!sin_ready) begin
        tests++;
        fails++;
        $error("FAIL ready_timeout: observed 0 expected 1");
      end
      sin_data  = v[21-i];
      sin_valid = 1'b1;
      step();
    end
    sin_valid = 1'b0;
    sin_data  = 1'b0;
  endtask

  task automatic expect_good(input string tag);
    chk({tag, "_chk_busy"}, busy, 1);
    chk({tag, "_chk_rdy"}, sin_ready, 0);
    step();
    chk({tag, "_kv_early"}, key_valid, 0);
    chk({tag, "_err"}, err, 0);
    step();
    chk({tag, "_kv"}, key_valid, 1);
    chk({tag, "_kp"}, key_p, 4'h3);
    chk({tag, "_kx"}, key_x, 14'h2A5C);
    chk({tag, "_fc"}, fail_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic expect_bad(input string tag, input logic [1:0] fc, input logic lo);
    step();
    chk({tag, "_err"}, err, 1);
    chk({tag, "_fc"}, fail_cnt, fc);
    chk({tag, "_lock"}, lockout, lo);
    chk({tag, "_kv"}, key_valid, 0);
    step();
    chk({tag, "_err_pulse"}, err, 0);
    chk({tag, "_kp"}, key_p, 0);
    chk({tag, "_kx"}, key_x, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; sin_data = 1'b0; sin_valid = 1'b0;
    #12;
    chk("rst_kv", key_valid, 0);
    chk("rst_rdy", sin_ready, 0);
    chk("rst_key", {key_x, key_p}, 0);
    chk("rst_fc", fail_cnt, 0);
    chk("rst_lock", lockout, 0);
    rst_n = 1'b1;
    step();

    // T2 good load
    pulse_start();
    chk("t2_busy", busy, 1);
    chk("t2_rdy", sin_ready, 1);
    stream(GoodKey, GoodChk, 1'b0, 22);
    expect_good("t2");

    // T6 clear in ACTIVE, then reload
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t6_kv", key_valid, 0);
    chk("t6_key", {key_x, key_p}, 0);
    pulse_start();
    stream(GoodKey, GoodChk, 1'b0, 22);
    expect_good("t6r");

    // T1 asynchronous reset mid-cycle while ACTIVE
    #3;
    rst_n = 1'b0;
    #1;
    chk("t1_kv", key_valid, 0);
    chk("t1_key", {key_x, key_p}, 0);
    chk("t1_rdy", sin_ready, 0);
    chk("t1_fc", fail_cnt, 0);
    rst_n = 1'b1;
    step();

    // T3 bad checksum
    pulse_start();
    stream(GoodKey, BadChk, 1'b0, 22);
    expect_bad("t3", 2'd1, 1'b0);
    chk("t3_idle_busy", busy, 0);

    // T5 abort after 10 transfers keeps fail_cnt
    pulse_start();
    stream(GoodKey, GoodChk, 1'b0, 10);
    chk("t5a_busy_mid", busy, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t5a_busy", busy, 0);
    chk("t5a_rdy", sin_ready, 0);
    chk("t5a_kv", key_valid, 0);
    chk("t5a_fc", fail_cnt, 1);
    step();
    chk("t5a_start_needed", sin_ready, 0);

    // T5 stalled stream succeeds and clears fail_cnt
    pulse_start();
    stream(GoodKey, GoodChk, 1'b1, 22);
    expect_good("t5s");
    clear = 1'b1;
    step();
    clear = 1'b0;

    // T4 three bad loads -> lockout
    pulse_start();
    stream(GoodKey, BadChk, 1'b0, 22);
    expect_bad("t4a", 2'd1, 1'b0);
    pulse_start();
    stream(GoodKey, BadChk, 1'b0, 22);
    expect_bad("t4b", 2'd2, 1'b0);
    pulse_start();
    stream(GoodKey, BadChk, 1'b0, 22);
    expect_bad("t4c", 2'd3, 1'b1);
    pulse_start();
    chk("t4_start_ign", sin_ready, 0);
    chk("t4_start_busy", busy, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    chk("t4_clear_ign", lockout, 1);
    chk("t4_clear_fc", fail_cnt, 3);
    chk("t4_kv", key_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_lock", lockout, 0);
    chk("t4_rst_fc", fail_cnt, 0);
    rst_n = 1'b1;
    step();
    pulse_start();
    stream(GoodKey, GoodChk, 1'b0, 22);
    expect_good("t4r");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
